// File: rtl/ram_port_arbiter.sv
// Two-requester front end for a single-port synchronous RAM: optional zero-fill after
// reset, then round-robin arbitration with registered RAM drive and per-port read return.
module ram_port_arbiter #(
    parameter int MEM_WIDTH_DATA = 8,
    parameter int MEM_DEPTH      = 256,
    parameter int WIDTH_MEM_ADDR = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic                      a_we,
    input  logic [WIDTH_MEM_ADDR-1:0] a_addr,
    input  logic [MEM_WIDTH_DATA-1:0] a_wdata,
    output logic                      a_rvalid,
    output logic [MEM_WIDTH_DATA-1:0] a_rdata,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic                      b_we,
    input  logic [WIDTH_MEM_ADDR-1:0] b_addr,
    input  logic [MEM_WIDTH_DATA-1:0] b_wdata,
    output logic                      b_rvalid,
    output logic [MEM_WIDTH_DATA-1:0] b_rdata,
    output logic                      ram_we,
    output logic [WIDTH_MEM_ADDR-1:0] ram_addr,
    output logic [MEM_WIDTH_DATA-1:0] ram_wdata,
    input  logic [MEM_WIDTH_DATA-1:0] ram_rdata,
    output logic                      init_done,
    output logic [1:0]                dbg_state
);

    localparam logic [WIDTH_MEM_ADDR-1:0] LAST_ADDR = WIDTH_MEM_ADDR'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_CLEAR = 2'd1,
        S_ARB   = 2'd2
    } state_t;

    state_t                      r_state;
    logic                        r_prio_b;
    logic                        r_ram_we;
    logic [WIDTH_MEM_ADDR-1:0]   r_ram_addr;
    logic [MEM_WIDTH_DATA-1:0]   r_ram_wdata;
    logic                        r_init_done;
    logic                        r_tag1_v;
    logic                        r_tag1_b;
    logic                        r_tag2_v;
    logic                        r_tag2_b;
    logic                        r_a_rvalid;
    logic                        r_b_rvalid;
    logic [MEM_WIDTH_DATA-1:0]   r_a_rdata;
    logic [MEM_WIDTH_DATA-1:0]   r_b_rdata;

    logic w_arb;
    logic w_grant_a;
    logic w_grant_b;
    logic w_contest;

    // Handshake: a command transfers on the rising edge where valid && ready are both high;
    // ready is combinational from valid, the arbiter state and the round-robin pointer.
    assign w_arb     = (r_state == S_ARB) && !rst;
    assign w_grant_a = w_arb && a_valid && (!b_valid || !r_prio_b);
    assign w_grant_b = w_arb && b_valid && (!a_valid ||  r_prio_b);
    assign w_contest = w_arb && a_valid && b_valid;

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign init_done = r_init_done;
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESET;
            r_prio_b    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_init_done <= 1'b0;
            r_tag1_v    <= 1'b0;
            r_tag1_b    <= 1'b0;
            r_tag2_v    <= 1'b0;
            r_tag2_b    <= 1'b0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
        end else begin
            r_ram_we <= 1'b0;
            r_tag1_v <= 1'b0;

            // Tag stage 2 lines up with the RAM sampling the address; its output is valid a cycle later.
            r_tag2_v   <= r_tag1_v;
            r_tag2_b   <= r_tag1_b;
            r_a_rvalid <= r_tag2_v && !r_tag2_b;
            r_b_rvalid <= r_tag2_v &&  r_tag2_b;
            if (r_tag2_v && !r_tag2_b) begin
                r_a_rdata <= ram_rdata;
            end
            if (r_tag2_v && r_tag2_b) begin
                r_b_rdata <= ram_rdata;
            end

            case (r_state)
                S_RESET: begin
                    if (CLEAR_ON_RESET != 0) begin
                        r_state     <= S_CLEAR;
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= '0;
                        r_ram_wdata <= '0;
                    end else begin
                        r_state     <= S_ARB;
                        r_init_done <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // ram_addr doubles as the clear counter and never steps past the last word.
                    if (r_ram_addr == LAST_ADDR) begin
                        r_state     <= S_ARB;
                        r_init_done <= 1'b1;
                    end else begin
                        r_ram_addr <= r_ram_addr + 1'b1;
                        r_ram_we   <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (w_grant_a) begin
                        r_ram_we    <= a_we;
                        r_ram_addr  <= a_addr;
                        r_ram_wdata <= a_wdata;
                        r_tag1_v    <= !a_we;
                        r_tag1_b    <= 1'b0;
                    end else if (w_grant_b) begin
                        r_ram_we    <= b_we;
                        r_ram_addr  <= b_addr;
                        r_ram_wdata <= b_wdata;
                        r_tag1_v    <= !b_we;
                        r_tag1_b    <= 1'b1;
                    end
                    if (w_contest) begin
                        r_prio_b <= !r_prio_b;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, arbitration/bus reference model and a
// read-return scoreboard, plus a second instance with a non power-of-two depth.
module tb_ram_port_arbiter;

    localparam int DW     = 8;
    localparam int AW     = 8;
    localparam int DEPTH  = 256;
    localparam int DEPTH2 = 200;
    localparam int EW     = 16 + 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ready, b_ready, a_rvalid, b_rvalid, ram_we, init_done;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW-1:0] ram_addr;
    logic [1:0]    dbg_state;

    ram_port_arbiter #(
        .MEM_WIDTH_DATA(DW), .MEM_DEPTH(DEPTH), .WIDTH_MEM_ADDR(AW), .CLEAR_ON_RESET(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .init_done(init_done), .dbg_state(dbg_state)
    );

    // Second instance: depth 200 in an 8-bit address space, requesters idle.
    logic          d2_a_ready, d2_b_ready, d2_a_rvalid, d2_b_rvalid, d2_ram_we, d2_init_done;
    logic [DW-1:0] d2_a_rdata, d2_b_rdata, d2_ram_wdata;
    logic [DW-1:0] d2_ram_rdata = '0;
    logic [AW-1:0] d2_ram_addr;
    logic [1:0]    d2_dbg_state;
    logic          d2_zero = 1'b0;
    logic [AW-1:0] d2_zaddr = '0;
    logic [DW-1:0] d2_zdata = '0;

    ram_port_arbiter #(
        .MEM_WIDTH_DATA(DW), .MEM_DEPTH(DEPTH2), .WIDTH_MEM_ADDR(AW), .CLEAR_ON_RESET(1)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .a_valid(d2_zero), .a_ready(d2_a_ready), .a_we(d2_zero), .a_addr(d2_zaddr), .a_wdata(d2_zdata),
        .a_rvalid(d2_a_rvalid), .a_rdata(d2_a_rdata),
        .b_valid(d2_zero), .b_ready(d2_b_ready), .b_we(d2_zero), .b_addr(d2_zaddr), .b_wdata(d2_zdata),
        .b_rvalid(d2_b_rvalid), .b_rdata(d2_b_rdata),
        .ram_we(d2_ram_we), .ram_addr(d2_ram_addr), .ram_wdata(d2_ram_wdata), .ram_rdata(d2_ram_rdata),
        .init_done(d2_init_done), .dbg_state(d2_dbg_state)
    );

    // ---------------- behavioural RAM, read-first, 1-cycle latency ----------------
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int d2_cnt = 0, d2_bad = 0, d2_seq = 0;
    logic [AW-1:0] d2_last = '0;
    always @(posedge clk) begin
        if (rst) begin
            d2_cnt <= 0; d2_bad <= 0; d2_seq <= 0;
        end else if (d2_ram_we) begin
            d2_cnt  <= d2_cnt + 1;
            d2_last <= d2_ram_addr;
            if (int'(d2_ram_addr) >= DEPTH2) d2_bad <= d2_bad + 1;
            if (int'(d2_ram_addr) != d2_cnt) d2_seq <= d2_seq + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] shadow [DEPTH];
    bit            mon_en = 1'b0, m_prio_b = 1'b0, m_ea, m_eb;
    bit            m_fire_a = 1'b0, m_fire_b = 1'b0;
    bit            pend_v = 1'b0, pend_we = 1'b0;
    logic [AW-1:0] pend_addr = '0, last_addr = '0;
    logic [DW-1:0] pend_wdata = '0;
    logic [EW-1:0] sb_got, sb_exp;
    logic [15:0]   c16;

    always @(negedge clk) begin
        c16 = 16'(cyc);
        if (a_rvalid || b_rvalid) begin
            check("rv_one_hot", 32'(a_rvalid && b_rvalid), 0);
            if (exp_q.size() == 0) begin
                check("rv_spurious", {30'd0, a_rvalid, b_rvalid}, 0);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_got = {c16, b_rvalid, (b_rvalid ? b_rdata : a_rdata)};
                check("rv_cycle_port_data", 32'(sb_got), 32'(sb_exp));
            end
        end else if (exp_q.size() != 0 && exp_q[0][EW-1 -: 16] <= c16) begin
            sb_exp = exp_q.pop_front();
            check("rv_missing", 32'(c16), 32'(sb_exp[EW-1 -: 16]));
        end

        if (rst) begin
            exp_q.delete();
            m_prio_b = 1'b0; pend_v = 1'b0; m_fire_a = 1'b0; m_fire_b = 1'b0;
            for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        end else if (mon_en) begin
            if (pend_v) begin
                check("bus_we", 32'(ram_we), 32'(pend_we));
                check("bus_addr", 32'(ram_addr), 32'(pend_addr));
                if (pend_we) check("bus_wdata", 32'(ram_wdata), 32'(pend_wdata));
                last_addr = pend_addr;
            end else begin
                check("bus_idle_we", 32'(ram_we), 0);
                check("bus_idle_addr", 32'(ram_addr), 32'(last_addr));
            end
            m_ea = a_valid && (!b_valid || !m_prio_b);
            m_eb = b_valid && (!a_valid ||  m_prio_b);
            check("a_ready", 32'(a_ready), 32'(m_ea));
            check("b_ready", 32'(b_ready), 32'(m_eb));
            pend_v = m_ea || m_eb;
            if (m_ea) begin
                pend_we = a_we; pend_addr = a_addr; pend_wdata = a_wdata;
            end else if (m_eb) begin
                pend_we = b_we; pend_addr = b_addr; pend_wdata = b_wdata;
            end
            if (pend_v) begin
                if (pend_we) shadow[pend_addr] = pend_wdata;
                else exp_q.push_back({c16 + 16'd3, m_eb, shadow[pend_addr]});
            end
            if (a_valid && b_valid) m_prio_b = !m_prio_b;
            m_fire_a = m_ea;
            m_fire_b = m_eb;
        end else begin
            m_fire_a = 1'b0;
            m_fire_b = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cmd_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit done = 1'b0;
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
        for (int t = 0; t < 50 && !done; t++) begin
            @(posedge clk); #1;
            done = m_fire_a;
        end
        if (!done) check("a_cmd_timeout", 1, 0);
        a_valid = 1'b0;
    endtask

    task automatic cmd_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit done = 1'b0;
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
        for (int t = 0; t < 50 && !done; t++) begin
            @(posedge clk); #1;
            done = m_fire_b;
        end
        if (!done) check("b_cmd_timeout", 1, 0);
        b_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Called with rst already high: checks the reset cycle, the full clear sweep and the handover to arbitration.
    task automatic reset_tail();
        a_valid = 1'b1; a_we = 1'b0; b_valid = 1'b1; b_we = 1'b0;
        @(negedge clk);
        check("rst_ready", {30'd0, a_ready, b_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_after_ready", {30'd0, a_ready, b_ready}, 0);
        check("rst_rdata_known", 32'($isunknown({a_rdata, b_rdata})), 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("clr_we", 32'(ram_we), 1);
            check("clr_addr", 32'(ram_addr), 32'(i));
            check("clr_wdata", 32'(ram_wdata), 0);
            check("clr_ready", {30'd0, a_ready, b_ready}, 0);
            check("clr_init_done", 32'(init_done), 0);
            if (i == DEPTH - 1) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("clr_end_we", 32'(ram_we), 0);
        check("clr_end_init_done", 32'(init_done), 1);
        check("clr_end_addr", 32'(ram_addr), 32'(DEPTH - 1));
        check("d2_init_done", 32'(d2_init_done), 1);
        check("d2_write_count", 32'(d2_cnt), 32'(DEPTH2));
        check("d2_out_of_range", 32'(d2_bad), 0);
        check("d2_sequence", 32'(d2_seq), 0);
        check("d2_last_addr", 32'(d2_last), 32'(DEPTH2 - 1));
        check("d2_we_idle", 32'(d2_ram_we), 0);
        @(posedge clk); #1;
        pend_v = 1'b0;
        last_addr = AW'(DEPTH - 1);
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        reset_tail();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();

        // RAW across ports: A writes, B reads the same word the next cycle.
        cmd_a(1'b1, 8'h10, 8'hA5);
        cmd_b(1'b0, 8'h10, 8'h00);
        idle_cycles(5);

        // Contested reads alternate starting with A.
        for (int i = 0; i < 6; i++) cmd_a(1'b1, AW'(8'h20 + i), DW'(8'h30 + 7 * i));
        a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h20;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 8'h23;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_grant", {30'd0, a_ready, b_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            if (m_fire_a) a_addr = a_addr + 1'b1;
            if (m_fire_b) b_addr = b_addr + 1'b1;
        end
        idle_cycles(6);

        // A wins the contest, then drops valid: B is granted next and drives ram_addr.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h40;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 8'h50;
        @(negedge clk);
        check("t6_a_wins", {30'd0, a_ready, b_ready}, 2);
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        check("t6_b_next", 32'(b_ready), 1);
        check("t6_addr_a", 32'(ram_addr), 32'h40);
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(negedge clk);
        check("t6_addr_b", 32'(ram_addr), 32'h50);
        @(posedge clk); #1;
        idle_cycles(5);

        // Two reads in flight when rst hits: no rvalid may follow.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h21;
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 8'h24;
        @(posedge clk); #1;
        b_valid = 1'b0;
        rst = 1'b1;
        reset_tail();

        // Random traffic with holds, withdrawals, back-to-back and same-address collisions.
        for (int n = 0; n < 500; n++) begin
            if (!a_valid || m_fire_a) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_we    = $urandom_range(0, 1);
                a_addr  = AW'($urandom_range(0, 15));
                a_wdata = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                a_valid = 1'b0;
            end
            if (!b_valid || m_fire_b) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_we    = $urandom_range(0, 1);
                b_addr  = AW'($urandom_range(0, 15));
                b_wdata = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                b_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        idle_cycles(8);
        check("drain_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
